// File: rtl/riscv_pkg.sv
// Shared RV32I core constants: datapath width, result-source and ALU encodings,
// and register-index helpers used by the pipeline registers.
package riscv_pkg;

  localparam int XLEN_DEFAULT      = 32;
  localparam int ALUCTRL_W_DEFAULT = 3;
  localparam int REG_W             = 5;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  localparam logic [1:0] RESULT_ALU = 2'b00;
  localparam logic [1:0] RESULT_MEM = 2'b01;
  localparam logic [1:0] RESULT_PC4 = 2'b10;

  localparam logic [ALUCTRL_W_DEFAULT-1:0] ALU_ADD = 3'b000;
  localparam logic [ALUCTRL_W_DEFAULT-1:0] ALU_SUB = 3'b001;
  localparam logic [ALUCTRL_W_DEFAULT-1:0] ALU_AND = 3'b010;
  localparam logic [ALUCTRL_W_DEFAULT-1:0] ALU_OR  = 3'b011;
  localparam logic [ALUCTRL_W_DEFAULT-1:0] ALU_XOR = 3'b100;
  localparam logic [ALUCTRL_W_DEFAULT-1:0] ALU_SLT = 3'b101;
  localparam logic [ALUCTRL_W_DEFAULT-1:0] ALU_SLL = 3'b110;
  localparam logic [ALUCTRL_W_DEFAULT-1:0] ALU_SRL = 3'b111;

endpackage

// File: rtl/pipe_reg_en_clr.sv
// Generic pipeline register with synchronous reset, clear (bubble) and load enable.
// Priority: reset > clr > en.
module pipe_reg_en_clr #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)     q <= '0;
    else if (clr)  q <= '0;
    else if (en)   q <= d;
  end

endmodule

// File: rtl/id_ex_reg.sv
// Decode-to-execute pipeline register with stall/flush and load-use detection.
// Optional macro ID_EX_PERF_EN adds bubble_cnt/stall_cnt performance counters.
module id_ex_reg
  import riscv_pkg::*;
#(
  parameter int XLEN      = riscv_pkg::XLEN_DEFAULT,
  parameter int ALUCTRL_W = riscv_pkg::ALUCTRL_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall_e,
  input  logic                 flush_e,
  input  logic                 valid_d,
  input  logic [XLEN-1:0]      pc_d,
  input  logic [XLEN-1:0]      pc_plus4_d,
  input  logic [XLEN-1:0]      rd1_d,
  input  logic [XLEN-1:0]      rd2_d,
  input  logic [XLEN-1:0]      imm_ext_d,
  input  logic [4:0]           rs1_d,
  input  logic [4:0]           rs2_d,
  input  logic [4:0]           rd_d,
  input  logic                 reg_write_d,
  input  logic [1:0]           result_src_d,
  input  logic                 mem_write_d,
  input  logic                 jump_d,
  input  logic                 branch_d,
  input  logic                 alu_src_d,
  input  logic [ALUCTRL_W-1:0] alu_control_d,
`ifdef ID_EX_PERF_EN
  output logic [31:0]          bubble_cnt,
  output logic [31:0]          stall_cnt,
`endif
  output logic                 valid_e,
  output logic [XLEN-1:0]      pc_e,
  output logic [XLEN-1:0]      pc_plus4_e,
  output logic [XLEN-1:0]      rd1_e,
  output logic [XLEN-1:0]      rd2_e,
  output logic [XLEN-1:0]      imm_ext_e,
  output logic [4:0]           rs1_e,
  output logic [4:0]           rs2_e,
  output logic [4:0]           rd_e,
  output logic                 reg_write_e,
  output logic [1:0]           result_src_e,
  output logic                 mem_write_e,
  output logic                 jump_e,
  output logic                 branch_e,
  output logic                 alu_src_e,
  output logic [ALUCTRL_W-1:0] alu_control_e,
  output logic                 load_use_d
);

  localparam int DATA_GW = 5*XLEN + 2*REG_W + 3 + ALUCTRL_W;
  localparam int CTRL_GW = 1 + REG_W + 4;

  logic               load_en;
  logic [DATA_GW-1:0] data_d, data_q;
  logic [CTRL_GW-1:0] ctrl_d, ctrl_q;

  assign load_en = ~stall_e;

  assign data_d = {pc_d, pc_plus4_d, rd1_d, rd2_d, imm_ext_d,
                   rs1_d, rs2_d, result_src_d, alu_src_d, alu_control_d};

  // An invalid decode slot still carries data, but must not write anything or name a destination.
  assign ctrl_d = {valid_d, rd_d & {REG_W{valid_d}}, reg_write_d & valid_d,
                   mem_write_d & valid_d, jump_d & valid_d, branch_d & valid_d};

  pipe_reg_en_clr #(.WIDTH(DATA_GW)) u_data (
    .clk(clk), .reset(reset), .en(load_en), .clr(flush_e), .d(data_d), .q(data_q)
  );

  pipe_reg_en_clr #(.WIDTH(CTRL_GW)) u_ctrl (
    .clk(clk), .reset(reset), .en(load_en), .clr(flush_e), .d(ctrl_d), .q(ctrl_q)
  );

  assign {pc_e, pc_plus4_e, rd1_e, rd2_e, imm_ext_e,
          rs1_e, rs2_e, result_src_e, alu_src_e, alu_control_e} = data_q;
  assign {valid_e, rd_e, reg_write_e, mem_write_e, jump_e, branch_e} = ctrl_q;

  assign load_use_d = valid_d & valid_e & (result_src_e == RESULT_MEM) &
                      (rd_e != REG_ZERO) & ((rd_e == rs1_d) | (rd_e == rs2_d));

`ifdef ID_EX_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (flush_e | (~stall_e & ~valid_d)) bubble_cnt <= bubble_cnt + 32'd1;
      if (stall_e & ~flush_e)              stall_cnt  <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed self-checking bench for id_ex_reg (define ID_EX_PERF_EN to also check counters).
module tb_id_ex_reg;

  logic        clk = 1'b0;
  logic        reset, stall_e, flush_e, valid_d;
  logic [31:0] pc_d, pc_plus4_d, rd1_d, rd2_d, imm_ext_d;
  logic [4:0]  rs1_d, rs2_d, rd_d;
  logic        reg_write_d, mem_write_d, jump_d, branch_d, alu_src_d;
  logic [1:0]  result_src_d;
  logic [2:0]  alu_control_d;
  logic        valid_e, reg_write_e, mem_write_e, jump_e, branch_e, alu_src_e, load_use_d;
  logic [31:0] pc_e, pc_plus4_e, rd1_e, rd2_e, imm_ext_e;
  logic [4:0]  rs1_e, rs2_e, rd_e;
  logic [1:0]  result_src_e;
  logic [2:0]  alu_control_e;
`ifdef ID_EX_PERF_EN
  logic [31:0] bubble_cnt, stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_ex_reg dut (
    .clk(clk), .reset(reset), .stall_e(stall_e), .flush_e(flush_e), .valid_d(valid_d),
    .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_ext_d(imm_ext_d),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .reg_write_d(reg_write_d),
    .result_src_d(result_src_d), .mem_write_d(mem_write_d), .jump_d(jump_d),
    .branch_d(branch_d), .alu_src_d(alu_src_d), .alu_control_d(alu_control_d),
`ifdef ID_EX_PERF_EN
    .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt),
`endif
    .valid_e(valid_e), .pc_e(pc_e), .pc_plus4_e(pc_plus4_e), .rd1_e(rd1_e), .rd2_e(rd2_e),
    .imm_ext_e(imm_ext_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .reg_write_e(reg_write_e), .result_src_e(result_src_e), .mem_write_e(mem_write_e),
    .jump_e(jump_e), .branch_e(branch_e), .alu_src_e(alu_src_e),
    .alu_control_e(alu_control_e), .load_use_d(load_use_d)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1; stall_e = 0; flush_e = 0; valid_d = 0;
    pc_d = 0; pc_plus4_d = 0; rd1_d = 0; rd2_d = 0; imm_ext_d = 0;
    rs1_d = 0; rs2_d = 0; rd_d = 0; reg_write_d = 0; result_src_d = 0;
    mem_write_d = 0; jump_d = 0; branch_d = 0; alu_src_d = 0; alu_control_d = 0;
    step(); step();
    chk("rst_valid", valid_e, 0);
    chk("rst_pc", pc_e, 0);
    chk("rst_rd", rd_e, 0);
    chk("rst_load_use", load_use_d, 0);
`ifdef ID_EX_PERF_EN
    chk("rst_bubble_cnt", bubble_cnt, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
`endif

    // First real instruction
    reset = 0;
    valid_d = 1; pc_d = 32'h100; pc_plus4_d = 32'h104; rd1_d = 32'hDEADBEEF;
    rd2_d = 32'h12345678; imm_ext_d = 32'hFFFFFFF0; rs1_d = 1; rs2_d = 2; rd_d = 5;
    reg_write_d = 1; result_src_d = 2'b00; alu_src_d = 1; alu_control_d = 3'b010;
    step();
    chk("load_pc", pc_e, 32'h100);
    chk("load_rd1", rd1_e, 32'hDEADBEEF);
    chk("load_rd", rd_e, 5);
    chk("load_reg_write", reg_write_e, 1);
    chk("load_valid", valid_e, 1);
    chk("load_imm", imm_ext_e, 32'hFFFFFFF0);
    chk("load_alu_ctrl", alu_control_e, 3'b010);
    chk("alu_op_no_hazard", load_use_d, 0);

    // lw x7 enters E
    pc_d = 32'h104; pc_plus4_d = 32'h108; rs1_d = 3; rs2_d = 4; rd_d = 7;
    result_src_d = 2'b01; alu_src_d = 1; alu_control_d = 3'b000;
    step();
    chk("lw_rd", rd_e, 7);
    chk("lw_result_src", result_src_e, 2'b01);
    rs1_d = 3; rs2_d = 7; #1;
    chk("lu_rs2_match", load_use_d, 1);
    rs1_d = 7; rs2_d = 0; #1;
    chk("lu_rs1_match", load_use_d, 1);
    valid_d = 0; #1;
    chk("lu_invalid_d", load_use_d, 0);
    valid_d = 1; rs1_d = 8; rs2_d = 8; #1;
    chk("lu_no_match", load_use_d, 0);

    // Hold for three cycles with changing decode inputs
    stall_e = 1;
    for (int i = 0; i < 3; i++) begin
      pc_d = 32'h500 + i*4; rd_d = 5'(20 + i); rd1_d = 32'h1111 * (i + 1); valid_d = i[0];
      step();
      chk("stall_pc", pc_e, 32'h104);
      chk("stall_rd", rd_e, 7);
      chk("stall_rd1", rd1_e, 32'hDEADBEEF);
      chk("stall_valid", valid_e, 1);
    end
`ifdef ID_EX_PERF_EN
    chk("stall_cnt_3", stall_cnt, 3);
    chk("bubble_cnt_0", bubble_cnt, 0);
`endif

    // Flush wins over stall
    flush_e = 1; valid_d = 1; mem_write_d = 1; rd_d = 11;
    step();
    chk("flush_mem_write", mem_write_e, 0);
    chk("flush_valid", valid_e, 0);
    chk("flush_rd", rd_e, 0);
    chk("flush_pc", pc_e, 0);
`ifdef ID_EX_PERF_EN
    chk("flush_bubble_cnt", bubble_cnt, 1);
    chk("flush_stall_cnt", stall_cnt, 3);
`endif

    // Load to x0: never a hazard
    flush_e = 0; stall_e = 0; mem_write_d = 0;
    rd_d = 0; result_src_d = 2'b01; rs1_d = 0; rs2_d = 0; pc_d = 32'h180;
    step();
    chk("x0_result_src", result_src_e, 2'b01);
    chk("x0_load_use", load_use_d, 0);

    // Invalid decode slot: data loads, side effects and rd are squashed
    valid_d = 0; reg_write_d = 1; rd_d = 9; mem_write_d = 1; jump_d = 1; branch_d = 1;
    pc_d = 32'h200;
    step();
    chk("inv_reg_write", reg_write_e, 0);
    chk("inv_rd", rd_e, 0);
    chk("inv_valid", valid_e, 0);
    chk("inv_mem_write", mem_write_e, 0);
    chk("inv_jump", jump_e, 0);
    chk("inv_branch", branch_e, 0);
    chk("inv_pc_loads", pc_e, 32'h200);
`ifdef ID_EX_PERF_EN
    chk("inv_bubble_cnt", bubble_cnt, 2);
`endif

    // Reset during a stall with live contents
    valid_d = 1; pc_d = 32'h300; rd_d = 10; mem_write_d = 0; jump_d = 0; branch_d = 0;
    result_src_d = 2'b01;
    step();
    chk("pre_rst_valid", valid_e, 1);
    stall_e = 1;
    step();
    reset = 1; rs1_d = 10;
    step();
    chk("mid_rst_valid", valid_e, 0);
    chk("mid_rst_pc", pc_e, 0);
    chk("mid_rst_rd", rd_e, 0);
    chk("mid_rst_reg_write", reg_write_e, 0);
    chk("mid_rst_load_use", load_use_d, 0);
`ifdef ID_EX_PERF_EN
    chk("mid_rst_bubble_cnt", bubble_cnt, 0);
    chk("mid_rst_stall_cnt", stall_cnt, 0);
`endif
    reset = 0; stall_e = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
